// File: rtl/mux4to1_pkg.sv
// Package for the 4:1 case-statement selector: select-code type and lane codes.
package mux4to1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_L0 = 2'd0;
    localparam sel_t SEL_L1 = 2'd1;
    localparam sel_t SEL_L2 = 2'd2;
    localparam sel_t SEL_L3 = 2'd3;

endpackage : mux4to1_pkg

// File: rtl/mux4to1_case_core.sv
// 4:1 lane selector decoded by a full case on sel, with a combinational
// output and a one-cycle registered copy (asynchronous active-low reset).
// Optional feature: define MUX4TO1_PARITY_EN to add par_q, the registered
// even parity of the selected lane, captured alongside out_q.
module mux4to1_case_core
    import mux4to1_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  sel_t                  sel,
    input  logic [4*DATA_W-1:0]   in,
    output logic [DATA_W-1:0]     out,
    output logic [DATA_W-1:0]     out_q
`ifdef MUX4TO1_PARITY_EN
    ,
    output logic                  par_q
`endif
);

    // Lane decode; the leading default keeps out at zero for unknown sel codes
    always_comb begin
        out = '0;
        case (sel)
            SEL_L0:  out = in[0*DATA_W +: DATA_W];
            SEL_L1:  out = in[1*DATA_W +: DATA_W];
            SEL_L2:  out = in[2*DATA_W +: DATA_W];
            SEL_L3:  out = in[3*DATA_W +: DATA_W];
            default: out = '0;
        endcase
    end

    // Registered copy of the selected lane, cleared at once by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

`ifdef MUX4TO1_PARITY_EN
    logic par_d;

    // Even parity of the combinational lane, so par_q lines up with out_q
    always_comb begin
        par_d = ^out;
    end

    // Parity register sharing the out_q capture edge and reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule : mux4to1_case_core

// File: tb/tb_mux4to1_case_core.sv
// Directed self-checking bench for mux4to1_case_core (DATA_W=1 and DATA_W=8).
module tb_mux4to1_case_core;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [3:0]  in1;
    logic        out1;
    logic        outq1;
    logic [31:0] in8;
    logic [7:0]  out8;
    logic [7:0]  outq8;
`ifdef MUX4TO1_PARITY_EN
    logic        par1;
    logic        par8;
`endif

    int checks;
    int fails;

    mux4to1_case_core #(.DATA_W(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .in    (in1),
        .out   (out1),
        .out_q (outq1)
`ifdef MUX4TO1_PARITY_EN
        ,
        .par_q (par1)
`endif
    );

    mux4to1_case_core #(.DATA_W(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .in    (in8),
        .out   (out8),
        .out_q (outq8)
`ifdef MUX4TO1_PARITY_EN
        ,
        .par_q (par8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 2'b00;
        in1   = 4'b1111;
        in8   = 32'hFFFF_FFFF;
        #2;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_outq1: got %b want 0", outq1);
        end
        checks++;
        if (outq8 !== 8'h00) begin
            fails++;
            $display("FAIL reset_outq8: got %h want 00", outq8);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold_outq1: got %b want 0", outq1);
        end
`ifdef MUX4TO1_PARITY_EN
        checks++;
        if (par8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_par8: got %b want 0", par8);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // exp_by_sel[s] is the hand-computed out for sel=s
    task automatic test_pattern(input logic [3:0] pat, input logic [3:0] exp_by_sel, input string tag);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            in1 = pat;
            sel = 2'(s);
            #1;
            checks++;
            if (out1 !== exp_by_sel[s]) begin
                fails++;
                $display("FAIL %s_out sel=%0d: got %b want %b", tag, s, out1, exp_by_sel[s]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (outq1 !== exp_by_sel[s]) begin
                fails++;
                $display("FAIL %s_outq sel=%0d: got %b want %b", tag, s, outq1, exp_by_sel[s]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in1 = 4'b0010;
        sel = 2'b01;
        @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b1) begin
            fails++;
            $display("FAIL arst_preload: got %b want 1", outq1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL arst_immediate: got %b want 0", outq1);
        end
        checks++;
        if (out1 !== 1'b1) begin
            fails++;
            $display("FAIL arst_out_tracks: got %b want 1", out1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL arst_hold: got %b want 0", outq1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL arst_release_noedge: got %b want 0", outq1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b1) begin
            fails++;
            $display("FAIL arst_first_edge: got %b want 1", outq1);
        end
    endtask

    task automatic test_sel_x();
        @(negedge clk);
        in1 = 4'b1110;
        sel = 2'bxx;
        #1;
        checks++;
        if (out1 !== 1'b0) begin
            fails++;
            $display("FAIL selx_out: got %b want 0", out1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL selx_outq: got %b want 0", outq1);
        end
        @(negedge clk);
        sel = 2'b00;
    endtask

    task automatic test_wide();
        in8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        @(negedge clk);
        sel = 2'b10;
        #1;
        checks++;
        if (out8 !== 8'hC3) begin
            fails++;
            $display("FAIL wide_out_sel2: got %h want c3", out8);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outq8 !== 8'hC3) begin
            fails++;
            $display("FAIL wide_outq_sel2: got %h want c3", outq8);
        end
`ifdef MUX4TO1_PARITY_EN
        checks++;
        if (par8 !== 1'b0) begin
            fails++;
            $display("FAIL wide_par_c3: got %b want 0", par8);
        end
`endif
        @(negedge clk);
        sel = 2'b00;
        #1;
        checks++;
        if (out8 !== 8'hA1) begin
            fails++;
            $display("FAIL wide_out_sel0: got %h want a1", out8);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outq8 !== 8'hA1) begin
            fails++;
            $display("FAIL wide_outq_sel0: got %h want a1", outq8);
        end
`ifdef MUX4TO1_PARITY_EN
        checks++;
        if (par8 !== 1'b1) begin
            fails++;
            $display("FAIL wide_par_a1: got %b want 1", par8);
        end
`endif
        @(negedge clk);
        sel = 2'b11;
        #1;
        checks++;
        if (out8 !== 8'hD4) begin
            fails++;
            $display("FAIL wide_out_sel3: got %h want d4", out8);
        end
        @(negedge clk);
        sel = 2'b01;
        #1;
        checks++;
        if (out8 !== 8'hB2) begin
            fails++;
            $display("FAIL wide_out_sel1: got %h want b2", out8);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        sel = 2'b00;
        in1 = 4'b0001;
        #1;
        checks++;
        if (out1 !== 1'b1) begin
            fails++;
            $display("FAIL same_before: got %b want 1", out1);
        end
        @(negedge clk);
        sel = 2'b11;
        in1 = 4'b1000;
        #1;
        checks++;
        if (out1 !== 1'b1) begin
            fails++;
            $display("FAIL same_after: got %b want 1", out1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b1) begin
            fails++;
            $display("FAIL same_outq: got %b want 1", outq1);
        end
        @(negedge clk);
        sel = 2'b00;
        #1;
        checks++;
        if (out1 !== 1'b0) begin
            fails++;
            $display("FAIL same_lane0_now0: got %b want 0", out1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outq1 !== 1'b0) begin
            fails++;
            $display("FAIL same_outq_lane0: got %b want 0", outq1);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_pattern(4'b1010, 4'b1010, "pat1010");
        test_pattern(4'b0101, 4'b0101, "pat0101");
        test_async_reset();
        test_sel_x();
        test_wide();
        test_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_mux4to1_case_core
